bus_xfer_ctrl: RTL
==================

Name: bus_xfer_ctrl

Overview:
- Downstream companion of the 3-master round-robin bus arbiter.
- Consumes the arbiter's gnt/sel, muxes the granted master's request onto the shared slave port, and runs a single-beat request/ready handshake with the selected slave.
- Returns read data to the granted master.
- Drives the ack level back to the arbiter. The arbiter treats the falling edge of ack as command-done.

Parameters:
- AW, 8, address width.
- DW, 32, data width.
- GAP_CYC, 3, cycles ack is held low after a transfer before a new grant is accepted (covers the arbiter's registered cmd_done lag). Legal range 1..15.
- TIMEOUT, 16, maximum REQ-state cycles before forced abort (used only with the optional feature). Legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- gnt  in  3  one-hot grant from arbiter.
- sel  in  2  slave select from arbiter: 01 = slave 0, 10 = slave 1.
- m_req  in  3  per-master transfer request.
- m_we  in  3  per-master write enable.
- m_addr0/1/2  in  AW  master 0/1/2 address.
- m_wdata0/1/2  in  DW  master 0/1/2 write data.
- m_rdata  out  DW  read data, shared to all masters.
- m_rvalid  out  3  one-hot completion strobe to the owning master.
- s_req  out  2  per-slave request.
- s_we  out  1  write enable to slave.
- s_addr  out  AW  address to slave.
- s_wdata  out  DW  write data to slave.
- s_ready  in  2  per-slave ready/complete.
- s_rdata0/1  in  DW  slave 0/1 read data.
- ack  out  1  high while a transfer is owned; falling edge = done.
- err  out  1  one-cycle strobe on abort or illegal select.

Behaviour:
- Reset (rst=0, async): state=IDLE. ack, err, s_req, s_we, m_rvalid, and the counters all 0. s_addr, s_wdata, m_rdata = 0. Applies immediately, including mid-transfer. No completion strobe is issued for an aborted transfer.
- States: IDLE, REQ, DONE, GAP.
- IDLE:
  - A start requires: gnt exactly one-hot, sel in {01,10}, and m_req of the granted master =1.
  - On start, on the clock edge: latch master index, slave index, addr, wdata, we. Go to REQ.
  - gnt one-hot with sel=11: err pulses for 1 cycle, stay IDLE.
  - gnt=000, multi-hot gnt, or sel=00: no action.
- REQ:
  - ack=1. s_req[slave]=1. s_addr/s_wdata/s_we come from the latched values.
  - s_ready[slave] sampled each cycle. When it is 1, capture s_rdata of that slave into m_rdata (also for writes) and go to DONE.
  - Minimum latency is start edge to DONE in 2 clocks.
  - s_ready of the unselected slave is ignored.
  - gnt, sel, and m_* changes while in REQ are ignored; the latched values rule.
- DONE (1 cycle):
  - ack=1, s_req=0, m_rvalid[master]=1. Go to GAP.
- GAP:
  - ack=0. The ack fall occurs at the DONE→GAP edge.
  - Hold for GAP_CYC cycles; gnt is ignored. Then go to IDLE.
  - A persistent m_req from the same master restarts only after GAP, and only if the arbiter still grants it.
- m_rdata holds its value until the next capture.
- s_req is never asserted on both bits at once.
- A 4-bit GAP counter and an 8-bit timeout counter, both saturating.

Optional Feature:
- Macro: XFER_TIMEOUT_EN.
- Defined:
  - The timeout counter increments each REQ cycle.
  - If TIMEOUT cycles elapse without s_ready, go to DONE with err=1 in the DONE cycle, m_rvalid still pulsed, and m_rdata forced to all-ones.
  - The counter clears on entry to REQ.
- Undefined:
  - No counter logic.
  - REQ waits indefinitely.
  - err pulses only for sel=11.

Test Plan:
- Write: gnt=001, sel=01, m_req[0]=1, m_we[0]=1, m_addr0=8'h10, m_wdata0=32'hA5A5_0001, s_ready[0]=1 after 2 REQ cycles -> s_req=01 for 3 cycles with s_addr=8'h10; m_rvalid=001 for 1 cycle; ack high 4 cycles then low for GAP_CYC=3.
- Read: gnt=100, sel=10, m_addr2=8'h44, s_rdata1=32'hDEAD_BEEF, ready in 1st REQ cycle -> m_rdata=32'hDEAD_BEEF, m_rvalid=100, err=0.
- Grant change mid-REQ: gnt 010→001 during REQ -> s_addr stays at m_addr1; completion goes to master 1 only.
- Illegal/multi-hot: sel=11 with gnt=010 -> err 1-cycle pulse, no s_req. gnt=011 -> nothing.
- Reset assert during REQ -> s_req, ack, and m_rvalid go to 0 without a clock. After release the block is in IDLE and a new transfer completes normally.
- XFER_TIMEOUT_EN, TIMEOUT=16, s_ready stuck 0 -> s_req high exactly 16 cycles; DONE has err=1, m_rdata=32'hFFFF_FFFF, m_rvalid pulse.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl
// Transfer controller behind the 3-master round-robin arbiter. It takes the
// arbiter's one-hot grant and slave select and routes the granted master's
// request to one of two slaves. It runs a single-beat req/ready handshake and
// returns the read data with a one-hot completion strobe. It also drives the
// ack level back to the arbiter, which treats the falling edge of ack as done.
// Optional build macro XFER_TIMEOUT_EN: adds an 8-bit REQ-state timeout. When
// it expires, the transfer is forced to complete with err=1 and all-ones read
// data.
module bus_xfer_ctrl #(
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int GAP_CYC = 3,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    gnt,
   input  logic [1:0]    sel,
   input  logic [2:0]    m_req,
   input  logic [2:0]    m_we,
   input  logic [AW-1:0] m_addr0,
   input  logic [AW-1:0] m_addr1,
   input  logic [AW-1:0] m_addr2,
   input  logic [DW-1:0] m_wdata0,
   input  logic [DW-1:0] m_wdata1,
   input  logic [DW-1:0] m_wdata2,
   output logic [DW-1:0] m_rdata,
   output logic [2:0]    m_rvalid,
   output logic [1:0]    s_req,
   output logic          s_we,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wdata,
   input  logic [1:0]    s_ready,
   input  logic [DW-1:0] s_rdata0,
   input  logic [DW-1:0] s_rdata1,
   output logic          ack,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, REQ, DONE, GAP} state_t;

   // Last GAP-counter value before returning to IDLE.
   localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

   // Reject out-of-range configurations at elaboration.
   if (GAP_CYC < 1 || GAP_CYC > 15) begin : g_bad_gap
      $error("bus_xfer_ctrl: GAP_CYC must be in 1..15");
   end
   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("bus_xfer_ctrl: TIMEOUT must be in 2..255");
   end

   state_t        state;
   logic [2:0]    mst_oh;      // granted master, latched at start
   logic          slv;         // selected slave index, latched at start
   logic [3:0]    gap_cnt;

   logic          gnt_ok;
   logic          sel_ok;
   logic          g_req;
   logic          g_we;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_wdata;
   logic [DW-1:0] slv_rdata;

`ifdef XFER_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0]    to_cnt;
`endif

   // Decode the grant and mux the granted master's address and write data.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
      gnt_ok  = 1'b1;
      g_addr  = m_addr0;
      g_wdata = m_wdata0;
      case (gnt)
         3'b001: ;
         3'b010: begin
            g_addr  = m_addr1;
            g_wdata = m_wdata1;
         end
         3'b100: begin
            g_addr  = m_addr2;
            g_wdata = m_wdata2;
         end
         default: gnt_ok = 1'b0;
      endcase
   end

   // With a one-hot grant, masking picks out exactly the granted master's bit.
   assign g_req     = |(m_req & gnt);
   assign g_we      = |(m_we & gnt);
   assign sel_ok    = (sel == 2'b01) || (sel == 2'b10);
   assign slv_rdata = slv ? s_rdata1 : s_rdata0;

   // Transfer FSM. All outputs are registered, and strobes default low each cycle.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      if (!rst) begin
         state    <= IDLE;
         mst_oh   <= '0;
         slv      <= 1'b0;
         gap_cnt  <= '0;
         ack      <= 1'b0;
         err      <= 1'b0;
         s_req    <= '0;
         s_we     <= 1'b0;
         s_addr   <= '0;
         s_wdata  <= '0;
         m_rdata  <= '0;
         m_rvalid <= '0;
`ifdef XFER_TIMEOUT_EN
         to_cnt   <= '0;
`endif
      end else begin
         err      <= 1'b0;
         m_rvalid <= '0;
         case (state)
            IDLE: begin
               if (gnt_ok && sel_ok && g_req) begin
                  mst_oh  <= gnt;
                  slv     <= sel[1];
                  s_req   <= sel;
                  s_we    <= g_we;
                  s_addr  <= g_addr;
                  s_wdata <= g_wdata;
                  ack     <= 1'b1;
`ifdef XFER_TIMEOUT_EN
                  to_cnt  <= '0;
`endif
                  state   <= REQ;
               end else if (gnt_ok && sel == 2'b11) begin
                  err <= 1'b1;
               end
            end
            REQ: begin
               // Only the selected slave's ready counts. Data is captured for writes too.
               if (s_ready[slv]) begin
                  m_rdata  <= slv_rdata;
                  s_req    <= '0;
                  s_we     <= 1'b0;
                  m_rvalid <= mst_oh;
                  state    <= DONE;
               end
`ifdef XFER_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  m_rdata  <= '1;
                  err      <= 1'b1;
                  s_req    <= '0;
                  s_we     <= 1'b0;
                  m_rvalid <= mst_oh;
                  state    <= DONE;
               end
               if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
`endif
            end
            DONE: begin
               // The arbiter takes this ack fall as command-done.
               ack     <= 1'b0;
               gap_cnt <= '0;
               state   <= GAP;
            end
            GAP: begin
               // Grants are ignored here to cover the arbiter's registered done lag.
               if (gap_cnt == GAP_LAST) state <= IDLE;
               else if (gap_cnt != 4'hF) gap_cnt <= gap_cnt + 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
